mem_byte_sequencer: RTL and testbench

Sequences 32-bit load/store requests from the pipeline MEM stage into single-byte accesses on the byte-wide asynchronous data memory (`DataMemoryAsync`: 13-bit address, 8-bit data, `rden`/`wren`). It supports byte, halfword and word accesses, with sign or zero extension on loads, in little-endian byte order. While a transfer is in progress it stalls the pipeline, then returns the assembled load data with a one-cycle `done` pulse.

---
 rtl/mem_byte_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// rtl/mem_byte_sequencer.sv - sequences 32-bit load/store requests into byte accesses on a byte-wide async memory
module mem_byte_sequencer #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data_in,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [7:0]        mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        last_q, last_d;       // index of the final byte: 0, 1 or 3
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       asm_q, asm_d;         // load bytes gathered so far
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [7:0]        mem_data_in_q, mem_data_in_d;
    logic              mem_rden_q, mem_rden_d;
    logic              mem_wren_q, mem_wren_d;
    logic              done_q, done_d;
    logic [1:0]        k_next;

    // Only the low address bits reach the memory; the rest are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    // Pipeline hold: the request cycle plus every access cycle.
    assign stall = ((state_q == S_IDLE) && req_valid) || (state_q == S_ACCESS);

    assign done        = done_q;
    assign rdata       = rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_rden    = mem_rden_q;
    assign mem_wren    = mem_wren_q;

    // Next-state logic; memory strobes are computed one cycle ahead so they leave flops.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        last_d        = last_q;
        uns_d         = uns_q;
        base_d        = base_q;
        wdata_d       = wdata_q;
        k_d           = k_q;
        asm_d         = asm_q;
        rdata_d       = rdata_q;
        mem_address_d = '0;
        mem_data_in_d = 8'h00;
        mem_rden_d    = 1'b0;
        mem_wren_d    = 1'b0;
        done_d        = 1'b0;
        k_next        = k_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d       = S_ACCESS;
                    write_d       = req_write;
                    case (req_size)
                        2'b00:   last_d = 2'd0;
                        2'b01:   last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                    uns_d         = req_unsigned;
                    base_d        = req_addr[ADDR_W-1:0];
                    wdata_d       = req_wdata;
                    k_d           = 2'd0;
                    asm_d         = 32'h0;
                    mem_address_d = req_addr[ADDR_W-1:0];
                    mem_wren_d    = req_write;
                    mem_rden_d    = !req_write;
                    mem_data_in_d = req_write ? req_wdata[7:0] : 8'h00;
                end
            end

            S_ACCESS: begin
                if (!write_q) begin
                    asm_d[8*k_q +: 8] = mem_data_out;
                end
                if (k_q == last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    k_d     = 2'd0;
                    if (!write_q) begin
                        case (last_q)
                            2'd0:    rdata_d = uns_q ? {24'h0, asm_d[7:0]}
                                                     : {{24{asm_d[7]}}, asm_d[7:0]};
                            2'd1:    rdata_d = uns_q ? {16'h0, asm_d[15:0]}
                                                     : {{16{asm_d[15]}}, asm_d[15:0]};
                            default: rdata_d = asm_d;
                        endcase
                    end
                end else begin
                    k_d           = k_next;
                    mem_address_d = base_q + {{(ADDR_W-2){1'b0}}, k_next};
                    mem_wren_d    = write_q;
                    mem_rden_d    = !write_q;
                    mem_data_in_d = write_q ? wdata_q[8*k_next +: 8] : 8'h00;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            write_q       <= 1'b0;
            last_q        <= 2'd0;
            uns_q         <= 1'b0;
            base_q        <= '0;
            wdata_q       <= 32'h0;
            k_q           <= 2'd0;
            asm_q         <= 32'h0;
            rdata_q       <= 32'h0;
            mem_address_q <= '0;
            mem_data_in_q <= 8'h00;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            last_q        <= last_d;
            uns_q         <= uns_d;
            base_q        <= base_d;
            wdata_q       <= wdata_d;
            k_q           <= k_d;
            asm_q         <= asm_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb/tb_mem_byte_sequencer.sv - directed self-checking bench for mem_byte_sequencer
module tb_mem_byte_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic [12:0] mem_address;
    logic [7:0]  mem_data_in;
    logic        mem_rden;
    logic        mem_wren;
    logic [7:0]  mem_data_out;

    logic        pl_we = 1'b0;
    logic [12:0] pl_a = 13'h0;
    logic [7:0]  pl_d = 8'h00;
    logic [7:0]  mem [0:8191];

    int tests = 0;
    int fails = 0;

    logic        c_acc  [0:15];
    logic        c_wr   [0:15];
    logic [12:0] c_addr [0:15];
    logic [7:0]  c_data [0:15];
    int          stall_cnt, acc_cnt, done_cnt, done_cyc, zero_bad;
    logic [31:0] rd_at_done;

    mem_byte_sequencer #(.ADDR_W(13)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .done         (done),
        .rdata        (rdata),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_rden     (mem_rden),
        .mem_wren     (mem_wren),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, clocked-write byte memory with a bench preload port.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_address] <= mem_data_in;
        else if (pl_we) mem[pl_a] <= pl_d;
    end
    assign mem_data_out = mem[mem_address];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_we = 1'b1;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    // Issue one request in cycle 0 and observe ncyc cycles; req_valid stays high
    // through cycle hold_cyc, reset is raised for the edge ending cycle rst_cyc.
    task automatic run(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int rst_cyc, input int hold_cyc, input int ncyc);
        stall_cnt = 0; acc_cnt = 0; done_cnt = 0; done_cyc = -1; zero_bad = 0;
        rd_at_done = 32'h0;
        for (int i = 0; i < 16; i++) begin
            c_acc[i] = 1'b0; c_wr[i] = 1'b0; c_addr[i] = 13'h0; c_data[i] = 8'h0;
        end
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_wren || mem_rden) begin
                acc_cnt++;
                c_acc[cyc] = 1'b1; c_wr[cyc] = mem_wren;
                c_addr[cyc] = mem_address; c_data[cyc] = mem_data_in;
                if (mem_wren && mem_rden) zero_bad++;
            end else if (mem_address != 13'h0 || mem_data_in != 8'h0) begin
                zero_bad++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    rd_at_done = rdata;
                end
            end
            if (cyc == rst_cyc) reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            if (cyc >= hold_cyc) req_valid = 1'b0;
        end
        req_valid = 1'b0;
    endtask

    // Check the access pattern for an n-byte transfer starting at a0.
    task automatic chk_pattern(input string tag, input int n, input logic w,
                               input logic [12:0] a0, input logic [31:0] wd);
        logic [12:0] a;
        chk({tag, " acc_cnt"}, acc_cnt, n);
        chk({tag, " done_cyc"}, done_cyc, n + 1);
        chk({tag, " done_cnt"}, done_cnt, 1);
        chk({tag, " stall_cnt"}, stall_cnt, n + 1);
        chk({tag, " idle_zero"}, zero_bad, 0);
        for (int i = 0; i < n; i++) begin
            a = a0 + 13'(i);
            chk({tag, " acc"}, {31'h0, c_acc[i+1]}, 32'h1);
            chk({tag, " wr"}, {31'h0, c_wr[i+1]}, {31'h0, w});
            chk({tag, " addr"}, {19'h0, c_addr[i+1]}, {19'h0, a});
            if (w) chk({tag, " data"}, {24'h0, c_data[i+1]}, {24'h0, wd[8*i +: 8]});
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst stall", {31'h0, stall}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst mem_ctl", {mem_address, mem_data_in, mem_rden, mem_wren}, 32'h0);
        @(posedge clk); #1;

        // Word store / load
        run(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, -1, 0, 7);
        chk_pattern("SW", 4, 1'b1, 13'h0010, 32'hDEAD_BEEF);
        chk("SW mem", {mem[13'h13], mem[13'h12], mem[13'h11], mem[13'h10]}, 32'hDEAD_BEEF);
        chk("SW rdata_kept", rdata, 32'h0);

        run(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, -1, 0, 7);
        chk_pattern("LW", 4, 1'b0, 13'h0010, 32'h0);
        chk("LW rdata", rd_at_done, 32'hDEAD_BEEF);

        // Sub-word loads
        run(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, -1, 0, 4);
        chk_pattern("LB", 1, 1'b0, 13'h0013, 32'h0);
        chk("LB rdata", rd_at_done, 32'hFFFF_FFDE);
        run(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, -1, 0, 4);
        chk("LBU rdata", rd_at_done, 32'h0000_00DE);
        chk("LBU done_cyc", done_cyc, 2);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0, -1, 0, 5);
        chk_pattern("LH", 2, 1'b0, 13'h0012, 32'h0);
        chk("LH rdata", rd_at_done, 32'hFFFF_DEAD);
        run(1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0, -1, 0, 5);
        chk("LHU rdata", rd_at_done, 32'h0000_BEEF);
        chk("LHU done_cyc", done_cyc, 3);

        // Size 11 behaves as word; upper address bits ignored
        run(1'b0, 2'b11, 1'b1, 32'hFFFF_E010, 32'h0, -1, 0, 7);
        chk_pattern("LW11", 4, 1'b0, 13'h0010, 32'h0);
        chk("LW11 rdata", rd_at_done, 32'hDEAD_BEEF);

        // Wrap-around
        run(1'b1, 2'b10, 1'b0, 32'h0000_1FFE, 32'h1122_3344, -1, 0, 7);
        chk_pattern("SWwrap", 4, 1'b1, 13'h1FFE, 32'h1122_3344);
        chk("SWwrap mem", {mem[13'h0001], mem[13'h0000], mem[13'h1FFF], mem[13'h1FFE]}, 32'h1122_3344);
        chk("SWwrap rdata_kept", rdata, 32'hDEAD_BEEF);
        run(1'b0, 2'b10, 1'b0, 32'h0000_1FFE, 32'h0, -1, 0, 7);
        chk("LWwrap rdata", rd_at_done, 32'h1122_3344);

        // Reset in the middle of a store
        preload(13'h0022, 8'h55);
        preload(13'h0023, 8'h66);
        run(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 2, 0, 5);
        chk("RST acc_cnt", acc_cnt, 2);
        chk("RST done_cnt", done_cnt, 0);
        chk("RST idle_zero", zero_bad, 0);
        chk("RST stall_cnt", stall_cnt, 3);
        chk("RST rdata", rdata, 32'h0);
        chk("RST mem", {mem[13'h23], mem[13'h22], mem[13'h21], mem[13'h20]}, 32'h6655_F00D);

        // Held request through DONE, then an immediate new request
        run(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, -1, 5, 6);
        chk_pattern("HOLD", 4, 1'b0, 13'h0010, 32'h0);
        chk("HOLD rdata", rd_at_done, 32'hDEAD_BEEF);
        run(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0, -1, 0, 4);
        chk_pattern("B2B", 1, 1'b0, 13'h0012, 32'h0);
        chk("B2B rdata", rd_at_done, 32'h0000_00AD);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
